branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage pipeline.
- Produces the branch direction and target prediction in IF.
- Resolves that prediction in ID against the actual branch outcome.
- Generates the ID_misprediction flag consumed by the branch hazard/flush logic, plus the corrected fetch PC.
- Direct-mapped branch target buffer (BTB); each entry holds a 2-bit saturating counter.

Parameters:
- INDEX_BITS, 4: BTB index width; ENTRIES = 2^INDEX_BITS.
- PC_WIDTH, 32: program counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- IF_pc  input  PC_WIDTH  PC of the instruction being fetched.
- IF_predict_taken  output  1  predicted taken for IF_pc.
- IF_predict_target  output  PC_WIDTH  predicted next PC: target if taken, else IF_pc+4.
- ID_pc  input  PC_WIDTH  PC of the instruction in ID.
- ID_is_branch  input  1  ID instruction is a conditional branch or direct jump.
- ID_branch_taken  input  1  actual direction resolved in ID.
- ID_branch_target  input  PC_WIDTH  actual target resolved in ID.
- ID_predicted_taken  input  1  IF_predict_taken carried through the IF/ID register.
- ID_predicted_target  input  PC_WIDTH  IF_predict_target carried through the IF/ID register.
- ID_stall  input  1  ID stage held; suppresses the update and the misprediction flag.
- ID_misprediction  output  1  prediction wrong; fetch must redirect.
- ID_correct_pc  output  PC_WIDTH  redirect PC: ID_branch_target if taken, else ID_pc+4.

Behaviour:
- Index and tag:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2].
- Entry fields: valid, tag, target[PC_WIDTH-1:0], ctr[1:0].
- Reset: all valid cleared to 0 and all ctr set to 2'b01 (weakly not taken), in one cycle.
  - While rst=1: IF_predict_taken=0, IF_predict_target=IF_pc+4, ID_misprediction=0.
  - ID_correct_pc stays combinational (formula below).
  - Reset asserted mid-operation discards any pending update.
- IF lookup (combinational, zero latency):
  - hit = valid & (tag match).
  - IF_predict_taken = hit & ctr[1].
  - IF_predict_target = IF_predict_taken ? target : IF_pc+4.
  - Arithmetic is modulo 2^PC_WIDTH; PC+4 wraps silently.
- ID resolution (combinational): ID_misprediction = ID_is_branch & ~ID_stall & ~rst & ((ID_branch_taken != ID_predicted_taken) | (ID_branch_taken & ID_predicted_target != ID_branch_target)).
- Update at the clock edge, only when ID_is_branch & ~ID_stall & ~rst, indexed by ID_pc:
  - Hit, taken: ctr saturating increment (max 2'b11); target <= ID_branch_target.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate with valid=1, tag, target, ctr=2'b10 (weakly taken); replaces any occupant.
  - Miss, not taken: no change.
- Counter state machine per entry: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11).
  - taken moves right; not taken moves left; saturates at the ends.
- Simultaneous IF read and ID write to the same index: IF sees the pre-update contents (no bypass); the new value is visible from the next cycle.
- Non-branch in ID (ID_is_branch=0): no update, ID_misprediction=0.
- Aliasing between two PCs with the same index: handled by the tag; a tag mismatch is a miss.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- When defined, add output ports stat_branches[31:0] and stat_mispredicts[31:0].
  - Both clear on rst.
  - stat_branches increments on every update-qualified cycle.
  - stat_mispredicts increments when ID_misprediction=1.
  - Both wrap at 2^32.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then IF_pc=0x0000_0040 -> IF_predict_taken=0, IF_predict_target=0x0000_0044; ID_is_branch=0 -> ID_misprediction=0.
- ID_pc=0x40, taken, target=0x100, predicted 0/0x44 -> ID_misprediction=1, ID_correct_pc=0x100.
  - Next cycle IF_pc=0x40 -> taken=1, target=0x100 (ctr=10).
- Same branch resolved taken twice, then not taken three times:
  - ctr 10->11->11->10->01->00.
  - IF prediction at 0x40: taken, taken, taken, not taken, not taken.
- Alias case: 0x40 allocated, then ID_pc=0x440 (same index, INDEX_BITS=4) taken to 0x200.
  - IF_pc=0x40 -> miss, not taken.
  - IF_pc=0x440 -> taken to 0x200.
- Target change: entry 0x40 predicted taken to 0x100, actual taken to 0x180.
  - ID_misprediction=1, ID_correct_pc=0x180; entry target becomes 0x180.
- ID_stall=1 with a mispredicting branch -> ID_misprediction=0 and no entry change.
  - rst asserted the same cycle as an allocate -> entry stays invalid.
  - With BRANCH_PREDICTOR_STATS_EN defined, stats are 0 after reset and reach 3/1 after 3 branches with 1 miss.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor: zero-latency IF lookup, ID-stage resolution and update.
// Optional counters enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] IF_pc,
  output logic                IF_predict_taken,
  output logic [PC_WIDTH-1:0] IF_predict_target,
  input  logic [PC_WIDTH-1:0] ID_pc,
  input  logic                ID_is_branch,
  input  logic                ID_branch_taken,
  input  logic [PC_WIDTH-1:0] ID_branch_target,
  input  logic                ID_predicted_taken,
  input  logic [PC_WIDTH-1:0] ID_predicted_target,
  input  logic                ID_stall,
  output logic                ID_misprediction,
  output logic [PC_WIDTH-1:0] ID_correct_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  logic                r_valid  [ENTRIES];
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] r_target [ENTRIES];
  ctr_e                r_ctr    [ENTRIES];

  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    case (c)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      ST:      return taken ? ST  : WT;
      default: return WNT;
    endcase
  endfunction

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic                  w_if_hit;
  logic [1:0]            w_if_ctr;
  logic [INDEX_BITS-1:0] w_id_idx;
  logic [TAG_W-1:0]      w_id_tag;
  logic                  w_id_hit;
  logic                  w_upd;
  ctr_e                  w_ctr_nxt;
  logic                  w_unused_lsbs;

  assign w_unused_lsbs = ^{IF_pc[1:0], ID_pc[1:0]};

  // IF lookup: purely combinational, reads the pre-update table contents
  assign w_if_idx = IF_pc[INDEX_BITS+1:2];
  assign w_if_tag = IF_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_if_ctr = r_ctr[w_if_idx];

  assign IF_predict_taken  = ~rst & w_if_hit & w_if_ctr[1];
  assign IF_predict_target = IF_predict_taken ? r_target[w_if_idx] : IF_pc + PC_WIDTH'(4);

  // ID resolution
  assign w_id_idx = ID_pc[INDEX_BITS+1:2];
  assign w_id_tag = ID_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign w_id_hit = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);
  assign w_upd    = ID_is_branch & ~ID_stall & ~rst;

  assign ID_misprediction = w_upd &
      ((ID_branch_taken != ID_predicted_taken) |
       (ID_branch_taken & (ID_predicted_target != ID_branch_target)));
  assign ID_correct_pc = ID_branch_taken ? ID_branch_target : ID_pc + PC_WIDTH'(4);

  // Next counter state for the entry addressed by ID; a taken miss allocates weakly taken
  always_comb begin
    w_ctr_nxt = r_ctr[w_id_idx];
    if (w_id_hit) begin
      w_ctr_nxt = ctr_step(r_ctr[w_id_idx], ID_branch_taken);
    end else if (ID_branch_taken) begin
      w_ctr_nxt = WT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= WNT;
      end
    end else if (w_upd && (w_id_hit || ID_branch_taken)) begin
      r_valid[w_id_idx] <= 1'b1;
      r_ctr[w_id_idx]   <= w_ctr_nxt;
    end
  end

  // Tag/target are data: no reset, written on taken hits and on allocation
  always_ff @(posedge clk) begin
    if (w_upd && ID_branch_taken) begin
      r_tag[w_id_idx]    <= w_id_tag;
      r_target[w_id_idx] <= ID_branch_target;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_upd) r_stat_branches <= r_stat_branches + 32'd1;
      if (ID_misprediction) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
